// File: rtl/jitter_sampler_pkg.sv
// Shared types for the PRNG-driven jitter path: word width, pair record, sampler FSM states.
package craft_rand_pkg;

  localparam int PRNG_W         = 16;
  localparam int FRAC_W_DEFAULT = 12;

  // Fractions are stored MSB-aligned in full PRNG-width fields so any FRAC_W fits.
  typedef struct packed {
    logic [PRNG_W-1:0] x;
    logic [PRNG_W-1:0] y;
  } jitter_t;

  typedef enum logic {
    GET_X = 1'b0,
    GET_Y = 1'b1
  } state_t;

endpackage

// File: rtl/jitter_sampler_fifo.sv
// Small circular buffer of jitter pairs; head is read straight from storage flops.
// Push is unconditional (caller reserves space); flush empties without touching storage.
module jitter_fifo
  import craft_rand_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  jitter_t                    push_data,
  output logic                       valid,
  input  logic                       ready,
  output jitter_t                    head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  jitter_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop;

  assign valid = (count != '0);
  assign pop   = valid & ready;
  assign head  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/jitter_sampler.sv
// Pairs consecutive PRNG words into (jx, jy) sub-pixel offsets and serves them via valid/ready.
// JITTER_STRATIFIED_EN replaces the coordinate MSBs with a 2^LOG2_SIDE grid cell index.
module jitter_sampler
  import craft_rand_pkg::*;
#(
  parameter int FRAC_W    = FRAC_W_DEFAULT,
  parameter int DEPTH     = 2,
  parameter int LOG2_SIDE = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              prng_en,
  input  logic [15:0]       prng_num,
  input  logic              restart,
  output logic              jit_valid,
  input  logic              jit_ready,
  output logic [FRAC_W-1:0] jit_x,
  output logic [FRAC_W-1:0] jit_y
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (FRAC_W < 1 || FRAC_W > PRNG_W || LOG2_SIDE >= FRAC_W || DEPTH < 2) begin : g_cfg_check
    $error("jitter_sampler: unsupported FRAC_W/LOG2_SIDE/DEPTH combination");
  end

  state_t            state, state_nxt;
  logic              take, push, pop;
  logic [FRAC_W-1:0] x_hold, jx, jy;
  logic [CW-1:0]     count;
  jitter_t           push_data, head;
  logic              unused_bits;

  assign pop     = jit_valid & jit_ready;
  assign prng_en = take & ~rst;

  // GET_X only starts a pair when the FIFO will have room for it at the push.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    push      = 1'b0;
    if (restart) begin
      state_nxt = GET_X;
    end else begin
      case (state)
        GET_X: begin
          if (count < CW'(DEPTH) || pop) begin
            take      = 1'b1;
            state_nxt = GET_Y;
          end
        end
        GET_Y: begin
          take      = 1'b1;
          push      = 1'b1;
          state_nxt = GET_X;
        end
        default: state_nxt = GET_X;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= GET_X;
      x_hold <= '0;
    end else begin
      state <= state_nxt;
      if (take && state == GET_X) x_hold <= prng_num[PRNG_W-1 -: FRAC_W];
    end
  end

`ifdef JITTER_STRATIFIED_EN
  logic [LOG2_SIDE-1:0] sx, sy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx <= '0;
      sy <= '0;
    end else if (restart) begin
      sx <= '0;
      sy <= '0;
    end else if (push) begin
      sx <= sx + 1'b1;
      if (sx == '1) sy <= sy + 1'b1;
    end
  end

  assign jx = {sx, x_hold[FRAC_W-1 -: FRAC_W-LOG2_SIDE]};
  assign jy = {sy, prng_num[PRNG_W-1 -: FRAC_W-LOG2_SIDE]};
`else
  assign jx = x_hold;
  assign jy = prng_num[PRNG_W-1 -: FRAC_W];
`endif

  always_comb begin
    push_data = '0;
    push_data.x[PRNG_W-1 -: FRAC_W] = jx;
    push_data.y[PRNG_W-1 -: FRAC_W] = jy;
  end

  jitter_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (restart),
    .push      (push),
    .push_data (push_data),
    .valid     (jit_valid),
    .ready     (jit_ready),
    .head      (head),
    .count     (count)
  );

  assign jit_x = head.x[PRNG_W-1 -: FRAC_W];
  assign jit_y = head.y[PRNG_W-1 -: FRAC_W];

  assign unused_bits = ^{prng_num, head, x_hold};

endmodule

// File: tb/tb_jitter_sampler.sv
// Bench for jitter_sampler with an in-bench xorshift16 source, directed table and random scoreboard.
module tb_jitter_sampler;

  localparam logic [15:0] SEED = 16'h1ACE;

  logic        clk = 1'b0;
  logic        rst;
  logic        prng_en;
  logic [15:0] prng_num;
  logic        restart;
  logic        jit_valid;
  logic        jit_ready;
  logic [11:0] jit_x;
  logic [11:0] jit_y;

  int checks = 0;
  int errors = 0;

  logic [15:0] gw [0:1023];
  logic [15:0] pst;
  int          wcnt;

  typedef struct {
    int rdy;
    int rs;
    int ev;
    int ee;
    int xi;
    int yi;
    int pi;
  } row_t;

  row_t rows [0:26];

  always #5 clk = ~clk;

  jitter_sampler #(.FRAC_W(12), .DEPTH(2), .LOG2_SIDE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .prng_en   (prng_en),
    .prng_num  (prng_num),
    .restart   (restart),
    .jit_valid (jit_valid),
    .jit_ready (jit_ready),
    .jit_x     (jit_x),
    .jit_y     (jit_y)
  );

  function automatic logic [15:0] xs(input logic [15:0] s);
    logic [15:0] t;
    t = s ^ (s << 7);
    t = t ^ (t >> 9);
    t = t ^ (t << 8);
    return t;
  endfunction

  // Expected coordinate for a word that ends up as the p-th pair since reset/restart.
  function automatic logic [11:0] ex(input logic [15:0] w, input int p);
`ifdef JITTER_STRATIFIED_EN
    return {2'(p % 4), w[15 -: 10]};
`else
    return w[15 -: 12];
`endif
  endfunction

  function automatic logic [11:0] ey(input logic [15:0] w, input int p);
`ifdef JITTER_STRATIFIED_EN
    return {2'((p / 4) % 4), w[15 -: 10]};
`else
    return w[15 -: 12];
`endif
  endfunction

  // PRNG source: the presented word is consumed exactly on edges where prng_en is high.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pst  <= SEED;
      wcnt <= 0;
    end else if (prng_en) begin
      pst  <= xs(pst);
      wcnt <= wcnt + 1;
    end
  end
  assign prng_num = pst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    int en_cnt;
    int k;
    int pops;
    int outst;
    logic exp_pop;

    rows = '{
      '{1,0,0,1, 0, 0,0}, '{1,0,0,1, 0, 0,0}, '{1,0,1,1, 0, 1,0}, '{1,0,0,1, 0, 0,0},
      '{0,0,1,1, 2, 3,1}, '{0,0,1,1, 2, 3,1}, '{0,0,1,0, 2, 3,1}, '{0,0,1,0, 2, 3,1},
      '{0,0,1,0, 2, 3,1}, '{0,0,1,0, 2, 3,1}, '{0,0,1,0, 2, 3,1}, '{1,0,1,1, 2, 3,1},
      '{1,0,1,1, 4, 5,2}, '{1,0,1,1, 6, 7,3}, '{1,0,0,1, 0, 0,0}, '{1,0,1,1, 8, 9,4},
      '{1,1,0,0, 0, 0,0}, '{1,0,0,1, 0, 0,0}, '{1,0,0,1, 0, 0,0}, '{1,0,1,1,11,12,0},
      '{0,0,0,1, 0, 0,0}, '{0,0,1,1,13,14,1}, '{0,0,1,1,13,14,1}, '{0,1,1,0,13,14,1},
      '{1,0,0,1, 0, 0,0}, '{1,0,0,1, 0, 0,0}, '{1,0,1,1,17,18,0}
    };

    gw[0] = SEED;
    for (int i = 1; i < 1024; i++) gw[i] = xs(gw[i-1]);

    rst = 1'b0; jit_ready = 1'b0; restart = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(jit_valid), 32'd0);
    chk("reset_x", 32'(jit_x), 32'd0);
    chk("reset_y", 32'(jit_y), 32'd0);
    chk("reset_en", 32'(prng_en), 32'd0);
    rst = 1'b0;

    // Directed table: stream, stall, release, restart in GET_Y, restart with FIFO full.
    for (int r = 0; r < 27; r++) begin
      jit_ready = (rows[r].rdy != 0);
      restart   = (rows[r].rs != 0);
      #1;
      chk($sformatf("tbl%0d_valid", r), 32'(jit_valid), 32'(rows[r].ev));
      chk($sformatf("tbl%0d_en", r), 32'(prng_en), 32'(rows[r].ee));
      if (rows[r].ev != 0) begin
        chk($sformatf("tbl%0d_x", r), 32'(jit_x), 32'(ex(gw[rows[r].xi], rows[r].pi)));
        chk($sformatf("tbl%0d_y", r), 32'(jit_y), 32'(ey(gw[rows[r].yi], rows[r].pi)));
      end
      @(posedge clk);
      #1;
    end
    restart = 1'b0;

    // Long stall from reset: exactly DEPTH pairs (4 words) consumed, then frozen.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    jit_ready = 1'b0;
    en_cnt = 0;
    repeat (20) begin
      #1;
      if (prng_en) en_cnt++;
      @(posedge clk);
      #1;
    end
    chk("stall_words", 32'(en_cnt), 32'd4);
    chk("stall_en", 32'(prng_en), 32'd0);
    chk("stall_prng_num", 32'(prng_num), 32'(gw[4]));
    chk("stall_valid", 32'(jit_valid), 32'd1);
    chk("stall_x", 32'(jit_x), 32'(ex(gw[0], 0)));
    chk("stall_y", 32'(jit_y), 32'(ey(gw[1], 0)));

    jit_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 12 && k < 4; c++) begin
      #1;
      if (jit_valid) begin
        chk($sformatf("drain%0d_x", k), 32'(jit_x), 32'(ex(gw[2*k], k)));
        chk($sformatf("drain%0d_y", k), 32'(jit_y), 32'(ey(gw[2*k+1], k)));
        k++;
      end
      @(posedge clk);
      #1;
    end
    chk("drain_pairs", 32'(k), 32'd4);

    // Asynchronous reset while full.
    jit_ready = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("full_valid", 32'(jit_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async_valid", 32'(jit_valid), 32'd0);
    chk("async_en", 32'(prng_en), 32'd0);
    chk("async_x", 32'(jit_x), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Random backpressure against a pair-count model of the word stream.
    pops = 0;
    for (int c = 0; c < 400; c++) begin
      jit_ready = ($urandom_range(0, 3) != 0);
      #1;
      outst   = wcnt / 2 - pops;
      exp_pop = (outst > 0) && jit_ready;
      chk("rnd_valid", 32'(jit_valid), 32'(outst > 0));
      chk("rnd_bound", 32'(outst <= 2), 32'd1);
      if (wcnt % 2 == 1) chk("rnd_en_y", 32'(prng_en), 32'd1);
      else chk("rnd_en_x", 32'(prng_en), 32'(outst < 2 || exp_pop));
      if (exp_pop) begin
        chk("rnd_x", 32'(jit_x), 32'(ex(gw[2*pops], pops)));
        chk("rnd_y", 32'(jit_y), 32'(ey(gw[2*pops+1], pops)));
        pops++;
      end
      @(posedge clk);
      #1;
    end
    chk("rnd_progress", 32'(pops > 50), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
